// File: rtl/micro_sequencer_pkg.sv
// Shared definitions for the microprogrammed sequencer: sequencing and state
// encodings, microword field layout and the idle control-word fill value.
package micro_sequencer_pkg;

    localparam logic [2:0] SEQ_NEXT     = 3'd0;
    localparam logic [2:0] SEQ_JUMP     = 3'd1;
    localparam logic [2:0] SEQ_WAITMFC  = 3'd2;
    localparam logic [2:0] SEQ_BRANCH   = 3'd3;
    localparam logic [2:0] SEQ_DISPATCH = 3'd4;
    localparam logic [2:0] SEQ_HALT     = 3'd5;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    // Active-low enables on the data path, so the idle word is all ones.
    localparam logic CTRL_IDLE_BIT = 1'b1;

    function automatic int csel_width(input int ncond);
        return (ncond > 1) ? $clog2(ncond) : 1;
    endfunction

    // Microword layout, MSB to LSB: {ctrl, next, seq[2:0], csel}.
    function automatic int seq_lsb(input int csel_w);
        return csel_w;
    endfunction

    function automatic int next_lsb(input int csel_w);
        return csel_w + 3;
    endfunction

    function automatic int ctrl_lsb(input int uaddr_w, input int csel_w);
        return csel_w + 3 + uaddr_w;
    endfunction

    function automatic int uword_width(input int cw_width, input int uaddr_w, input int csel_w);
        return cw_width + uaddr_w + 3 + csel_w;
    endfunction

endpackage

// File: rtl/micro_store.sv
// Register array with synchronous write and asynchronous read; used for both
// the control store and the opcode dispatch table.
module micro_store #(
    parameter int WIDTH   = 8,
    parameter int DEPTH_W = 4
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [WIDTH-1:0]   wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [WIDTH-1:0]   rdata
);

    logic [WIDTH-1:0] mem [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed control unit: steps a loadable control store and drives one
// registered control word per cycle to the data path.
module micro_sequencer
    import micro_sequencer_pkg::*;
#(
    parameter int CW_WIDTH = 48,
    parameter int UADDR_W  = 6,
    parameter int OPC_W    = 6,
    parameter int NCOND    = 8,
    parameter int TMO_W    = 4,
    parameter int CSEL_W   = csel_width(NCOND),
    parameter logic [CW_WIDTH-1:0] CTRL_IDLE = {CW_WIDTH{CTRL_IDLE_BIT}}
) (
    input  logic                                Clk,
    input  logic                                Reset,
    input  logic                                Start,
    input  logic                                LdE,
    input  logic [UADDR_W-1:0]                  LdAddr,
    input  logic [CW_WIDTH+UADDR_W+3+CSEL_W-1:0] LdData,
    input  logic                                DtE,
    input  logic [OPC_W-1:0]                    DtAddr,
    input  logic [UADDR_W-1:0]                  DtData,
    input  logic [OPC_W-1:0]                    Op,
    input  logic [NCOND-1:0]                    Cond,
    input  logic                                MFC,
    output logic [CW_WIDTH-1:0]                 Ctrl,
    output logic [UADDR_W-1:0]                  uPC,
    output logic                                Busy,
    output logic                                Halted,
    output logic                                Timeout
);

    localparam int UW       = uword_width(CW_WIDTH, UADDR_W, CSEL_W);
    localparam int SEQ_LSB  = seq_lsb(CSEL_W);
    localparam int NEXT_LSB = next_lsb(CSEL_W);
    localparam int CTRL_LSB = ctrl_lsb(UADDR_W, CSEL_W);
    localparam logic [TMO_W-1:0] TMO_MAX = {TMO_W{1'b1}};

    logic [1:0]          state, state_n;
    logic [UADDR_W-1:0]  upc, upc_inc, addr_n;
    logic [CW_WIDTH-1:0] ctrl_q;
    logic                timeout_q;
    logic [TMO_W-1:0]    wcnt, wcnt_n;
    logic [UADDR_W-1:0]  cur_next;
    logic [2:0]          cur_seq;
    logic [CSEL_W-1:0]   cur_csel;
    logic                stopped, cs_we, dt_we;
    logic                load, halt_go, start_go, tmo_set, cond_hit;
    logic [UW-1:0]       cs_rd, fetch_word;
    logic [UADDR_W-1:0]  dt_rd;

    assign stopped = (state == ST_IDLE) || (state == ST_HALT);
    assign cs_we   = LdE && stopped;
    assign dt_we   = DtE && stopped;
    assign upc_inc = upc + UADDR_W'(1);

    micro_store #(.WIDTH(UW), .DEPTH_W(UADDR_W)) u_cstore (
        .clk   (Clk),
        .we    (cs_we),
        .waddr (LdAddr),
        .wdata (LdData),
        .raddr (addr_n),
        .rdata (cs_rd)
    );

    micro_store #(.WIDTH(UADDR_W), .DEPTH_W(OPC_W)) u_dtab (
        .clk   (Clk),
        .we    (dt_we),
        .waddr (DtAddr),
        .wdata (DtData),
        .raddr (Op),
        .rdata (dt_rd)
    );

    // A write landing on the address being fetched is forwarded straight through.
    assign fetch_word = (cs_we && (LdAddr == addr_n)) ? LdData : cs_rd;

    always_comb begin
        cond_hit = 1'b0;
        for (int i = 0; i < NCOND; i++) begin
            if (int'(cur_csel) == i) cond_hit = Cond[i];
        end
    end

    always_comb begin
        state_n  = state;
        addr_n   = upc;
        wcnt_n   = wcnt;
        load     = 1'b0;
        halt_go  = 1'b0;
        start_go = 1'b0;
        tmo_set  = 1'b0;
        case (state)
            ST_RUN: begin
                case (cur_seq)
                    SEQ_JUMP: begin
                        addr_n = cur_next;
                        load   = 1'b1;
                    end
                    SEQ_WAITMFC: begin
                        if (MFC) begin
                            addr_n = upc_inc;
                            load   = 1'b1;
                        end else begin
                            state_n = ST_WAIT;
                            wcnt_n  = '0;
                        end
                    end
                    SEQ_BRANCH: begin
                        addr_n = cond_hit ? cur_next : upc_inc;
                        load   = 1'b1;
                    end
                    SEQ_DISPATCH: begin
                        addr_n = dt_rd;
                        load   = 1'b1;
                    end
                    SEQ_HALT: begin
                        state_n = ST_HALT;
                        halt_go = 1'b1;
                    end
                    default: begin
                        addr_n = upc_inc;
                        load   = 1'b1;
                    end
                endcase
            end
            ST_WAIT: begin
                wcnt_n = wcnt + TMO_W'(1);
                if (MFC) begin
                    state_n = ST_RUN;
                    addr_n  = upc_inc;
                    load    = 1'b1;
                end else if (wcnt_n == TMO_MAX) begin
                    state_n = ST_RUN;
                    addr_n  = cur_next;
                    load    = 1'b1;
                    tmo_set = 1'b1;
                end
            end
            default: begin
                if (Start) begin
                    state_n  = ST_RUN;
                    addr_n   = '0;
                    load     = 1'b1;
                    start_go = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            upc       <= '0;
            ctrl_q    <= CTRL_IDLE;
            timeout_q <= 1'b0;
            wcnt      <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            if (load) begin
                upc    <= addr_n;
                ctrl_q <= fetch_word[CTRL_LSB +: CW_WIDTH];
            end else if (halt_go) begin
                ctrl_q <= CTRL_IDLE;
            end
            if (tmo_set)       timeout_q <= 1'b1;
            else if (start_go) timeout_q <= 1'b0;
        end
    end

    // Sequencing fields of the word at uPC; the store cannot change while running.
    always_ff @(posedge Clk) begin
        if (load) begin
            cur_next <= fetch_word[NEXT_LSB +: UADDR_W];
            cur_seq  <= fetch_word[SEQ_LSB +: 3];
            cur_csel <= fetch_word[CSEL_W-1:0];
        end
    end

    assign Ctrl    = ctrl_q;
    assign uPC     = upc;
    assign Busy    = (state == ST_RUN) || (state == ST_WAIT);
    assign Halted  = (state == ST_HALT);
    assign Timeout = timeout_q;

endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the sequencing rules.
module tb_micro_sequencer;

    localparam int CW = 48;
    localparam int UA = 6;
    localparam int OW = 6;
    localparam int NC = 8;
    localparam int TW = 4;
    localparam int CS = 3;
    localparam int LW = CW + UA + 3 + CS;
    localparam int DEPTH = 64;

    logic          Clk = 1'b0;
    logic          Reset, Start, LdE, DtE, MFC;
    logic [UA-1:0] LdAddr;
    logic [LW-1:0] LdData;
    logic [OW-1:0] DtAddr;
    logic [UA-1:0] DtData;
    logic [OW-1:0] Op;
    logic [NC-1:0] Cond;
    logic [CW-1:0] Ctrl;
    logic [UA-1:0] uPC;
    logic          Busy, Halted, Timeout;

    always #5 Clk = ~Clk;

    micro_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .LdE(LdE), .LdAddr(LdAddr),
        .LdData(LdData), .DtE(DtE), .DtAddr(DtAddr), .DtData(DtData), .Op(Op),
        .Cond(Cond), .MFC(MFC), .Ctrl(Ctrl), .uPC(uPC), .Busy(Busy),
        .Halted(Halted), .Timeout(Timeout)
    );

    int tests  = 0;
    int failed = 0;

    // Behavioural model: store contents as separate fields, flags for the mode.
    logic [CW-1:0] m_ctrl [DEPTH];
    int            m_next [DEPTH];
    int            m_seq  [DEPTH];
    int            m_csel [DEPTH];
    int            m_dtab [DEPTH];
    bit            m_run, m_wait, m_halt, m_tmo;
    int            m_upc, m_wcnt;

    logic [CW-1:0] p_ctrl;
    int            p_next, p_seq, p_csel;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_run = 0; m_wait = 0; m_halt = 0; m_tmo = 0; m_upc = 0; m_wcnt = 0;
    endtask

    task automatic model_step();
        int cur;
        cur = m_upc;
        if (!(m_run || m_wait)) begin
            if (LdE) begin
                m_ctrl[LdAddr] = p_ctrl; m_next[LdAddr] = p_next;
                m_seq[LdAddr]  = p_seq;  m_csel[LdAddr] = p_csel;
            end
            if (DtE) m_dtab[DtAddr] = int'(DtData);
            if (Start) begin
                m_run = 1; m_halt = 0; m_upc = 0; m_tmo = 0;
            end
        end else if (m_run) begin
            case (m_seq[cur])
                1: m_upc = m_next[cur];
                2: if (MFC) m_upc = (cur + 1) % DEPTH;
                   else begin m_run = 0; m_wait = 1; m_wcnt = 0; end
                3: m_upc = (m_csel[cur] < NC && Cond[m_csel[cur]]) ? m_next[cur] : (cur + 1) % DEPTH;
                4: m_upc = m_dtab[Op];
                5: begin m_run = 0; m_halt = 1; end
                default: m_upc = (cur + 1) % DEPTH;
            endcase
        end else begin
            m_wcnt++;
            if (MFC) begin
                m_wait = 0; m_run = 1; m_upc = (cur + 1) % DEPTH;
            end else if (m_wcnt == 2**TW - 1) begin
                m_wait = 0; m_run = 1; m_upc = m_next[cur]; m_tmo = 1;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        logic [CW-1:0] exp_ctrl;
        exp_ctrl = (m_run || m_wait) ? m_ctrl[m_upc] : {CW{1'b1}};
        check({tag, ".ctrl"},    64'(Ctrl),    64'(exp_ctrl));
        check({tag, ".upc"},     64'(uPC),     64'(m_upc));
        check({tag, ".busy"},    64'(Busy),    64'(m_run || m_wait));
        check({tag, ".halted"},  64'(Halted),  64'(m_halt));
        check({tag, ".timeout"}, 64'(Timeout), 64'(m_tmo));
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge Clk);
        #1;
        compare_all(tag);
    endtask

    task automatic set_ld(input int addr, input logic [CW-1:0] c, input int n, input int s, input int cs);
        LdAddr = UA'(addr);
        LdData = {c, UA'(n), 3'(s), CS'(cs)};
        p_ctrl = c; p_next = n; p_seq = s; p_csel = cs;
    endtask

    task automatic load_word(input int addr, input logic [CW-1:0] c, input int n, input int s, input int cs);
        set_ld(addr, c, n, s, cs);
        LdE = 1'b1;
        tick("load");
        LdE = 1'b0;
    endtask

    task automatic start_pulse(input string tag);
        Start = 1'b1;
        tick(tag);
        Start = 1'b0;
    endtask

    task automatic async_reset(input string tag);
        @(negedge Clk);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        @(posedge Clk);
        #1;
        Reset = 1'b0;
        compare_all({tag, "_rel"});
    endtask

    initial begin
        logic [63:0] r64;
        for (int i = 0; i < DEPTH; i++) begin
            m_ctrl[i] = '0; m_next[i] = 0; m_seq[i] = 0; m_csel[i] = 0; m_dtab[i] = 0;
        end
        Reset = 1'b1; Start = 0; LdE = 0; DtE = 0; MFC = 0;
        LdAddr = '0; LdData = '0; DtAddr = '0; DtData = '0; Op = '0; Cond = '0;
        p_ctrl = '0; p_next = 0; p_seq = 0; p_csel = 0;
        model_reset();

        // Power-on reset, then idle with Start low
        @(posedge Clk);
        #1;
        compare_all("por");
        Reset = 1'b0;
        for (int i = 0; i < 3; i++) tick("idle");
        check("idle_ctrl", 64'(Ctrl), 64'({CW{1'b1}}));

        DtAddr = 6'h04; DtData = 6'd40; DtE = 1'b1;
        tick("dtload");
        DtE = 1'b0;

        // Linear run; writes attempted while running must be dropped
        load_word(0, 48'h1, 0, 0, 0);
        load_word(1, 48'h2, 0, 0, 0);
        load_word(2, 48'h4, 0, 0, 0);
        load_word(3, 48'h8, 0, 0, 0);
        load_word(4, {CW{1'b1}}, 0, 5, 0);
        start_pulse("lin_a");
        set_ld(2, 48'hDEAD, 7, 1, 2);
        LdE = 1'b1; DtE = 1'b1; DtAddr = 6'h04; DtData = 6'd13;
        for (int i = 0; i < 5; i++) tick("lin_a_run");
        LdE = 1'b0; DtE = 1'b0;
        check("lin_a_halted", 64'(Halted), 64'd1);
        start_pulse("lin_b");
        check("lin_b_c0", 64'(Ctrl), 64'h1);
        tick("lin_b");
        check("lin_b_c1", 64'(Ctrl), 64'h2);
        tick("lin_b");
        check("lin_b_c2", 64'(Ctrl), 64'h4);
        tick("lin_b");
        check("lin_b_c3", 64'(Ctrl), 64'h8);
        tick("lin_b");
        tick("lin_b");
        check("lin_b_ctrl_end", 64'(Ctrl), 64'({CW{1'b1}}));
        check("lin_b_halted", 64'(Halted), 64'd1);
        check("lin_b_upc", 64'(uPC), 64'd4);

        // MFC handshake, then timeout
        load_word(0, 48'h10, 0, 0, 0);
        load_word(1, 48'h20, 9, 2, 0);
        load_word(2, 48'h30, 0, 5, 0);
        load_word(9, 48'h90, 0, 5, 0);
        start_pulse("mfc");
        tick("mfc");
        tick("mfc_enter");
        tick("mfc_w1");
        tick("mfc_w2");
        check("mfc_hold", 64'(Ctrl), 64'h20);
        MFC = 1'b1;
        tick("mfc_done");
        MFC = 1'b0;
        check("mfc_upc", 64'(uPC), 64'd2);
        tick("mfc_halt");
        start_pulse("tmo");
        tick("tmo");
        tick("tmo_enter");
        for (int i = 0; i < 15; i++) tick("tmo_wait");
        check("tmo_upc", 64'(uPC), 64'd9);
        check("tmo_flag", 64'(Timeout), 64'd1);
        tick("tmo_halt");
        start_pulse("tmo_clr");
        check("tmo_cleared", 64'(Timeout), 64'd0);
        for (int i = 0; i < 3; i++) tick("tmo_clr_run");
        MFC = 1'b1;
        tick("tmo_clr_mfc");
        MFC = 1'b0;
        tick("tmo_clr_halt");

        // Branch taken / not taken, then dispatch
        load_word(0, 48'h100, 0, 0, 0);
        load_word(1, 48'h200, 0, 0, 0);
        load_word(2, 48'h300, 20, 3, 3);
        load_word(3, 48'h400, 0, 4, 0);
        load_word(20, 48'h2000, 0, 5, 0);
        load_word(40, 48'h4000, 0, 5, 0);
        Cond = 8'h08;
        start_pulse("br_t");
        tick("br_t"); tick("br_t"); tick("br_t");
        check("br_taken_upc", 64'(uPC), 64'd20);
        tick("br_t_halt");
        Cond = 8'hF7;
        start_pulse("br_n");
        tick("br_n"); tick("br_n"); tick("br_n");
        check("br_not_upc", 64'(uPC), 64'd3);
        Op = 6'h04;
        tick("disp");
        check("disp_upc", 64'(uPC), 64'd40);
        tick("disp_halt");

        // Wrap from 63 to 0, then asynchronous reset while running
        load_word(0, 48'hA0, 63, 1, 0);
        load_word(63, 48'hA63, 0, 0, 0);
        start_pulse("wrap");
        tick("wrap");
        check("wrap_at63", 64'(uPC), 64'd63);
        tick("wrap");
        check("wrap_upc", 64'(uPC), 64'd0);
        tick("wrap");
        async_reset("arst");
        check("arst_ctrl", 64'(Ctrl), 64'({CW{1'b1}}));

        // Start together with a write to address 0
        set_ld(0, 48'h55, 0, 5, 0);
        LdE = 1'b1; Start = 1'b1;
        tick("bypass");
        LdE = 1'b0; Start = 1'b0;
        check("bypass_ctrl", 64'(Ctrl), 64'h55);
        tick("bypass_halt");

        // Randomized store contents and traffic
        async_reset("rnd_rst");
        for (int i = 0; i < DEPTH; i++) begin
            r64 = {$urandom(), $urandom()};
            set_ld(i, r64[CW-1:0], int'($urandom_range(0, 63)), int'($urandom_range(0, 7)),
                   int'($urandom_range(0, 7)));
            DtAddr = OW'(i); DtData = UA'($urandom_range(0, 63));
            LdE = 1'b1; DtE = 1'b1;
            tick("rnd_load");
        end
        LdE = 1'b0; DtE = 1'b0;
        for (int i = 0; i < 600; i++) begin
            r64 = {$urandom(), $urandom()};
            Start = ($urandom_range(0, 15) == 0);
            MFC   = (i % 100 < 70) ? ($urandom_range(0, 3) == 0) : 1'b0;
            Cond  = NC'($urandom());
            Op    = OW'($urandom());
            set_ld(int'($urandom_range(0, 63)), r64[CW-1:0], int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            LdE    = ($urandom_range(0, 7) == 0);
            DtE    = ($urandom_range(0, 7) == 0);
            DtAddr = OW'($urandom());
            DtData = UA'($urandom());
            tick("rnd");
        end
        Start = 0; LdE = 0; DtE = 0; MFC = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Parametrised microprogrammed control unit for the SPARC data path. It replaces hand-sequenced control-line stimulus with microcode held in a loadable control store. Each cycle it emits one control word (IRE, MDRE, MARE, nPCE, the mux selects, and so on) to DataPathV5. Sequencing supports linear stepping, jumps, condition branches, opcode dispatch, and a wait-for-MFC memory handshake with timeout.

Parameters:
CW_WIDTH, 48, control word width (data-path control lines, concatenated)
UADDR_W, 6, micro-address width; control store depth is 2**UADDR_W
OPC_W, 6, opcode width for the dispatch table; table depth is 2**OPC_W
NCOND, 8, number of condition inputs; condition select width is CSEL_W = clog2(NCOND)
TMO_W, 4, MFC timeout counter width; timeout occurs after 2**TMO_W-1 wait cycles
CTRL_IDLE, all-ones, control word driven when not running (active-low enables are all de-asserted)

Ports:
Clk  in  1  clock; all state updates on rising edge
Reset  in  1  asynchronous, active-high; clears all state
Start  in  1  pulse; starts execution at micro-address 0 (honoured only in IDLE or HALT)
LdE  in  1  control store write enable (honoured only in IDLE or HALT)
LdAddr  in  UADDR_W  control store write address
LdData  in  CW_WIDTH+UADDR_W+3+CSEL_W  microword: {ctrl, next, seq[2:0], csel}
DtE  in  1  dispatch table write enable (honoured only in IDLE or HALT)
DtAddr  in  OPC_W  dispatch table index
DtData  in  UADDR_W  dispatch target
Op  in  OPC_W  opcode from IR
Cond  in  NCOND  condition flags (ICC-derived, trap pending, etc.)
MFC  in  1  memory function complete
Ctrl  out  CW_WIDTH  registered control word to the data path
uPC  out  UADDR_W  current micro-address
Busy  out  1  high in RUN or WAIT
Halted  out  1  high in HALT
Timeout  out  1  sticky; set on MFC timeout, cleared by Start or Reset

Behaviour:
- States: IDLE, RUN, WAIT, HALT. Reset (async) forces IDLE, uPC=0, Ctrl=CTRL_IDLE, Timeout=0, wait counter=0. Store and table contents are not reset.
- Invariant: in RUN and WAIT, Ctrl equals mem[uPC].ctrl. Each transition loads uPC<=A and Ctrl<=mem[A].ctrl on the same edge, so there is no extra latency.
- IDLE/HALT + Start: go to RUN; uPC<=0; Ctrl<=mem[0].ctrl; Timeout<=0. Start is ignored in RUN/WAIT.
- seq encodings, evaluated on the current word in RUN:
  - 0 NEXT: A = uPC+1, wrapping modulo 2**UADDR_W.
  - 1 JUMP: A = next.
  - 2 WAITMFC: if MFC is high this cycle, A = uPC+1. Otherwise stay at the same uPC, enter WAIT, clear the counter.
  - 3 BRANCH: A = Cond[csel] ? next : uPC+1. If csel>=NCOND, the condition is false.
  - 4 DISPATCH: A = dtab[Op].
  - 5 HALT: go to HALT; Ctrl<=CTRL_IDLE; uPC holds.
  - 6, 7 reserved: treated as NEXT.
- WAIT: Ctrl and uPC hold and the counter increments each cycle.
  - MFC high: go to RUN with A = uPC+1. MFC takes priority over timeout in the same cycle.
  - Counter reaches 2**TMO_W-1 with MFC low: go to RUN with A = next; Timeout<=1.
- LdE and DtE take effect only in IDLE or HALT. Writes in RUN/WAIT are dropped silently. A write and Start in the same cycle: the write lands first, and the word fetched for address 0 reflects the new data if LdAddr==0 (write-through bypass).
- Reset mid-WAIT or mid-RUN returns to IDLE immediately (asynchronous). Ctrl goes to CTRL_IDLE without waiting for the clock.
- Busy=(RUN|WAIT); Halted=(state==HALT). Both are decoded from the registered state.

Decomposition:
- Shared package holds:
  - seq encodings SEQ_NEXT..SEQ_HALT
  - state encodings
  - microword field offset functions of CW_WIDTH/UADDR_W/CSEL_W
  - CTRL_IDLE default
- Sub-module micro_store: synchronous-write, asynchronous-read register array parametrised by width and depth. Instantiated twice, once for the control store and once for the dispatch table.

Test Plan:
- Reset/idle: assert Reset mid-cycle -> Ctrl=all-ones, uPC=0, Busy=0 immediately; release and hold Start=0 -> outputs remain unchanged.
- Linear run: load words 0..3 as NEXT with ctrl=0x1,0x2,0x4,0x8, and word 4 as HALT; pulse Start -> Ctrl shows 1,2,4,8 on consecutive cycles, then all-ones; Halted=1, uPC=4.
- Fetch handshake: word 1 WAITMFC(next=9); raise MFC 3 cycles after entry -> Ctrl holds word-1 value for 3 cycles, then uPC=2. Keep MFC low instead -> uPC=9 after 15 cycles and Timeout=1.
- Branch/dispatch: word 2 BRANCH csel=3 next=20 -> uPC=20 with Cond[3]=1, uPC=3 with Cond[3]=0. Word 3 DISPATCH with dtab[0x04]=40 and Op=0x04 -> uPC=40.
- Boundary: NEXT at address 63 wraps to uPC=0. LdE during RUN leaves memory unchanged (read back after HALT). Start together with LdE to address 0 -> first Ctrl equals the newly written ctrl.
